// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state type and saturating-count helper for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [1:0] {
    RST_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN
  } pll_state_e;

  localparam logic [3:0] SAT_MAX = 4'hF;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == SAT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchronizer for a single asynchronous level, clears to 0 on reset
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - holds PLL reset, qualifies lock on clkin and releases the system reset
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 40000,
  parameter int STABLE_CYCLES = 4000,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       pll_ready,
  output logic [3:0] retry_cnt,
  output logic [3:0] loss_cnt
);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             lock_s;
  logic             retry_bump, loss_bump;
  logic             pll_reset_d, sys_reset_d, pll_ready_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q   <= RST_PLL;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      pll_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      pll_reset <= pll_reset_d;
      sys_reset <= sys_reset_d;
      pll_ready <= pll_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retry_bump = 1'b0;
    loss_bump  = 1'b0;
    if (restart && (state_q != RST_PLL)) begin
      state_d = RST_PLL;
    end else begin
      case (state_q)
        RST_PLL: begin
          if (cnt_q == RESET_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABILIZE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d    = RST_PLL;
            retry_bump = 1'b1;
          end
        end
        STABILIZE: begin
          if (!lock_s) state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = RUN;
        end
        RUN: begin
          if (!lock_s) begin
            state_d   = RST_PLL;
            loss_bump = 1'b1;
          end
        end
        default: state_d = RST_PLL;
      endcase
    end
  end

  always_comb begin
    pll_reset_d = (state_d == RST_PLL);
    sys_reset_d = (state_d != RUN);
    pll_ready_d = (state_d == RUN);
  end

  // Cleared on every state entry; frozen in RUN so it can never wrap.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q != RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      retry_cnt <= 4'd0;
      loss_cnt  <= 4'd0;
    end else begin
      if (retry_bump) retry_cnt <= sat_inc(retry_cnt);
      if (loss_bump)  loss_cnt  <= sat_inc(loss_cnt);
    end
  end

endmodule
